// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// The master holds one word-read request at a time until the memory acknowledges it.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetch stage: issues word reads, buffers returned words with their PCs
// in a small FIFO, and presents the head instruction with opcode/funct split out.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    fetch_unit_if.master             mem,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     pc_load,
    output logic                     valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [5:0]               opcode,
    output logic [5:0]               funct,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [31:0]     fetch_pc_r, fetch_pc_s;
    logic            req_r, req_s;
    logic [31:0]     addr_r, addr_s;
    logic [CW-1:0]   count_r, count_s;
    logic [PW-1:0]   rd_ptr_r, rd_ptr_s;
    logic [PW-1:0]   wr_ptr_r, wr_ptr_s;
    logic [31:0]     data_mem_r [DEPTH];
    logic [31:0]     pc_mem_r   [DEPTH];
    logic            push_s;
    logic            pop_s;
    logic [31:0]     target_s;
    logic            unused_s;

    assign target_s = {redirect_pc[31:2], 2'b00};
    assign unused_s = ^redirect_pc[1:0];

    // FIFO bookkeeping: a redirect flushes and overrides any same-cycle push or pop
    always_comb begin
        push_s   = (state_r == REQ) && mem.mem_ack && !redirect;
        pop_s    = pc_load && (count_r != {CW{1'b0}}) && !redirect;
        count_s  = count_r;
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        if (redirect) begin
            count_s  = {CW{1'b0}};
            rd_ptr_s = {PW{1'b0}};
            wr_ptr_s = {PW{1'b0}};
        end else begin
            if (push_s && !pop_s) begin
                count_s = count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_s = count_r - CW'(1);
            end else begin
                count_s = count_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
        end
    end

    // Request FSM: next state, request/address registers and the next fetch PC
    always_comb begin
        state_s    = state_r;
        req_s      = req_r;
        addr_s     = addr_r;
        fetch_pc_s = fetch_pc_r;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    state_s    = REQ;
                    req_s      = 1'b1;
                    addr_s     = target_s;
                    fetch_pc_s = target_s;
                end else if (count_r < FULL_C) begin
                    state_s = REQ;
                    req_s   = 1'b1;
                    addr_s  = fetch_pc_r;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_s = target_s;
                    if (mem.mem_ack) begin
                        addr_s = target_s;
                    end else begin
                        state_s = DROP;
                    end
                end else if (mem.mem_ack) begin
                    fetch_pc_s = addr_r + 32'd4;
                    if (count_s < FULL_C) begin
                        addr_s = addr_r + 32'd4;
                    end else begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DROP: begin
                // The stale request stays up until acked; its data never enters the FIFO
                if (mem.mem_ack) begin
                    state_s    = REQ;
                    addr_s     = redirect ? target_s : fetch_pc_r;
                    fetch_pc_s = redirect ? target_s : fetch_pc_r;
                end else if (redirect) begin
                    fetch_pc_s = target_s;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s    = IDLE;
                req_s      = 1'b0;
                addr_s     = fetch_pc_r;
                fetch_pc_s = fetch_pc_r;
            end
        endcase
    end

    // Control and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            req_r      <= req_s;
            addr_r     <= addr_s;
            count_r    <= count_s;
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
        end
    end

    // FIFO storage; contents are only visible through the occupancy-gated head
    always_ff @(posedge clock) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= mem.mem_rdata;
            pc_mem_r[wr_ptr_r]   <= addr_r;
        end
    end

    assign mem.mem_req  = req_r;
    assign mem.mem_addr = addr_r;
    assign count        = count_r;
    assign valid        = (count_r != {CW{1'b0}});
    assign instr        = valid ? data_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign instr_pc     = valid ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;
    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bench-side memory supplies words, and a scoreboard
// queue of expected {pc, word} pairs is compared against the FIFO head on each pop.
module tb_fetch_unit;
    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_load;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    fetch_unit_if mem_bus ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem         (mem_bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_load     (pc_load),
        .valid       (valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .funct       (funct),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_head(input string tag);
        logic [63:0] e;
        chk({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q[0];
            chk({tag, "_pc"}, instr_pc, e[63:32]);
            chk({tag, "_instr"}, instr, e[31:0]);
        end
    endtask

    // Drive a returned word onto the bus and record what the FIFO should hold
    task automatic ack_word(input logic [31:0] a, input logic [31:0] w);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = w;
        sb_q.push_back({a, w});
    endtask

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        pc_load = 1'b0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        #1;
        chk("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'h0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Zero-wait fill: four back-to-back requests, then stop with a full FIFO
        for (int i = 0; i < 4; i++) begin
            chk("fill_req", {31'd0, mem_bus.mem_req}, 32'd1);
            chk("fill_addr", mem_bus.mem_addr, 32'(4 * i));
            ack_word(32'(4 * i), word_at(32'(4 * i)));
            step();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
        end
        mem_bus.mem_ack = 1'b0;
        chk("full_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("full_valid", {31'd0, valid}, 32'd1);
        chk("full_pc", instr_pc, 32'h0);
        check_head("full_head");

        // Pop one from full, then refill with a push coinciding with a pop
        pc_load = 1'b1;
        void'(sb_q.pop_front());
        step();
        pc_load = 1'b0;
        chk("pop_count", {29'd0, count}, 32'd3);
        chk("pop_pc", instr_pc, 32'h4);
        chk("pop_req", {31'd0, mem_bus.mem_req}, 32'd0);
        step();
        chk("refill_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("refill_addr", mem_bus.mem_addr, 32'h10);
        check_head("pp_head");
        ack_word(32'h10, word_at(32'h10));
        pc_load = 1'b1;
        void'(sb_q.pop_front());
        step();
        mem_bus.mem_ack = 1'b0;
        pc_load = 1'b0;
        chk("pp_count", {29'd0, count}, 32'd3);
        chk("pp_addr", mem_bus.mem_addr, 32'h14);
        check_head("pp_next_head");

        // Asynchronous reset in the middle of an outstanding request
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("arst_addr", mem_bus.mem_addr, 32'h0);
        chk("arst_count", {29'd0, count}, 32'd0);
        sb_q.delete();
        step();
        reset = 1'b0;
        step();

        // Three-cycle ack latency: address held, valid one cycle after the ack edge
        for (int i = 0; i < 3; i++) begin
            chk("lat_req", {31'd0, mem_bus.mem_req}, 32'd1);
            chk("lat_addr", mem_bus.mem_addr, 32'h0);
            chk("lat_valid_lo", {31'd0, valid}, 32'd0);
            if (i < 2) step();
        end
        ack_word(32'h0, 32'h8C01_0004);
        step();
        chk("lat_valid_hi", {31'd0, valid}, 32'd1);
        chk("lat_opcode", {26'd0, opcode}, 32'h23);
        chk("lat_funct", {26'd0, funct}, 32'h04);
        check_head("lat_head");

        // Redirect while a request to 0x8 is pending without ack
        ack_word(32'h4, word_at(32'h4));
        step();
        chk("pre_rd_addr", mem_bus.mem_addr, 32'h8);
        mem_bus.mem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        sb_q.delete();
        chk("rd_count", {29'd0, count}, 32'd0);
        chk("rd_valid", {31'd0, valid}, 32'd0);
        chk("rd_instr_zero", instr, 32'h0);
        chk("rd_pc_zero", instr_pc, 32'h0);
        chk("drop_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("drop_addr", mem_bus.mem_addr, 32'h8);
        step();
        chk("drop_hold", mem_bus.mem_addr, 32'h8);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("drop_discard", {29'd0, count}, 32'd0);
        chk("drop_next_addr", mem_bus.mem_addr, 32'h40);
        ack_word(32'h40, word_at(32'h40));
        step();
        mem_bus.mem_ack = 1'b0;
        chk("rd_first_valid", {31'd0, valid}, 32'd1);
        chk("rd_first_pc", instr_pc, 32'h40);
        check_head("rd_head");

        // Redirect with simultaneous ack and pop, to an unaligned target near the top
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = word_at(32'h44);
        pc_load = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        mem_bus.mem_ack = 1'b0;
        sb_q.delete();
        chk("rda_count", {29'd0, count}, 32'd0);
        chk("rda_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("rda_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
        step();
        chk("empty_pop_count", {29'd0, count}, 32'd0);
        chk("empty_pop_valid", {31'd0, valid}, 32'd0);
        pc_load = 1'b0;
        ack_word(32'hFFFF_FFFC, word_at(32'hFFFF_FFFC));
        step();
        chk("wrap_addr", mem_bus.mem_addr, 32'h0);
        chk("wrap_count", {29'd0, count}, 32'd1);
        ack_word(32'h0, word_at(32'h0));
        step();
        mem_bus.mem_ack = 1'b0;
        chk("wrap_next_addr", mem_bus.mem_addr, 32'h4);
        check_head("wrap_head0");
        pc_load = 1'b1;
        void'(sb_q.pop_front());
        step();
        pc_load = 1'b0;
        chk("wrap_pop_count", {29'd0, count}, 32'd1);
        check_head("wrap_head1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
